// File: rtl/hazard_stall_ctrl.sv
// Load-use and multiply/divide hazard detection for the ID stage: drives the ID/EX bubble and the PC / IF/ID holds.
// Optional stall statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] RsAddr_id,
  input  logic [4:0] RtAddr_id,
  input  logic       UsesRs_id,
  input  logic       UsesRt_id,
  input  logic       MEM_MemRead_ex,
  input  logic [4:0] WrAddr_ex,
  input  logic       MD_Start_id,
  input  logic       MD_Op_id,
  input  logic       HiLoRead_id,
  output logic       stall,
  output logic       PC_we,
  output logic       IF_ID_we,
  output logic       md_busy,
  output logic       md_done
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] lu_stall_cnt,
  output logic [31:0] md_stall_cnt
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] load_val;
  logic             lu, mh, accept;

  assign lu = MEM_MemRead_ex && (WrAddr_ex != 5'd0) &&
              ((UsesRs_id && (RsAddr_id == WrAddr_ex)) ||
               (UsesRt_id && (RtAddr_id == WrAddr_ex)));
  // In the done cycle HI/LO is forwarded, so readers and new starts proceed.
  assign mh       = md_busy && (HiLoRead_id || MD_Start_id) && !md_done;
  assign stall    = lu || mh || rst;
  assign PC_we    = !stall;
  assign IF_ID_we = !stall;
  assign accept   = MD_Start_id && !stall;
  assign load_val = MD_Op_id ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = BUSY;
          cnt_nxt   = load_val;
        end
      end
      BUSY: begin
        if (cnt == CNT_W'(1)) begin
          if (accept) begin
            cnt_nxt = load_val;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    md_busy = (state == BUSY);
    md_done = (state == BUSY) && (cnt == CNT_W'(1));
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_stall_cnt <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (lu && (lu_stall_cnt != 32'hFFFF_FFFF)) lu_stall_cnt <= lu_stall_cnt + 32'd1;
      if (mh && (md_stall_cnt != 32'hFFFF_FFFF)) md_stall_cnt <= md_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: expected {stall,PC_we,IF_ID_we,md_busy,md_done} per cycle
// is queued when inputs are driven and popped at the following falling edge.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] RsAddr_id = '0, RtAddr_id = '0, WrAddr_ex = '0;
  logic       UsesRs_id = 0, UsesRt_id = 0, MEM_MemRead_ex = 0;
  logic       MD_Start_id = 0, MD_Op_id = 0, HiLoRead_id = 0;
  logic       stall, PC_we, IF_ID_we, md_busy, md_done;
`ifdef HAZARD_STATS_EN
  logic [31:0] lu_stall_cnt, md_stall_cnt;
`endif

  hazard_stall_ctrl dut (
    .clk(clk), .rst(rst),
    .RsAddr_id(RsAddr_id), .RtAddr_id(RtAddr_id),
    .UsesRs_id(UsesRs_id), .UsesRt_id(UsesRt_id),
    .MEM_MemRead_ex(MEM_MemRead_ex), .WrAddr_ex(WrAddr_ex),
    .MD_Start_id(MD_Start_id), .MD_Op_id(MD_Op_id), .HiLoRead_id(HiLoRead_id),
    .stall(stall), .PC_we(PC_we), .IF_ID_we(IF_ID_we),
    .md_busy(md_busy), .md_done(md_done)
`ifdef HAZARD_STATS_EN
    , .lu_stall_cnt(lu_stall_cnt), .md_stall_cnt(md_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] v;
    string      nm;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [4:0] obs;
  assign obs = {stall, PC_we, IF_ID_we, md_busy, md_done};

  // Expected vectors {stall, PC_we, IF_ID_we, md_busy, md_done}
  localparam logic [4:0] RUN  = 5'b01100;
  localparam logic [4:0] RSTV = 5'b10000;
  localparam logic [4:0] LUS  = 5'b10000;
  localparam logic [4:0] MDS  = 5'b10010;
  localparam logic [4:0] BSY  = 5'b01110;
  localparam logic [4:0] DONE = 5'b01111;

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                        input logic mr, input logic [4:0] wr, input logic mds, input logic op,
                        input logic hlr);
    RsAddr_id = rs; RtAddr_id = rt; UsesRs_id = urs; UsesRt_id = urt;
    MEM_MemRead_ex = mr; WrAddr_ex = wr; MD_Start_id = mds; MD_Op_id = op; HiLoRead_id = hlr;
  endtask

  task automatic idle_in();
    set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      next_cycle(); rst = 1'b1; idle_in();
      sb.push_back('{RSTV, "reset_hold"});
      @(negedge clk); e = sb.pop_front(); n_chk++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b want %b", e.nm, obs, e.v); end
    end
    next_cycle(); rst = 1'b0; idle_in();
    sb.push_back('{RUN, "reset_release"});
    @(negedge clk); e = sb.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b want %b", e.nm, obs, e.v); end
  endtask

  task automatic test_load_use();
    // lw $5 in EX, add $6,$5,$7 in ID reads Rt=5
    next_cycle(); set_in(5'd7, 5'd5, 1, 1, 1, 5'd5, 0, 0, 0);
    sb.push_back('{LUS, "lu_rt"});
    @(negedge clk); e = sb.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b want %b", e.nm, obs, e.v); end
    next_cycle(); set_in(5'd7, 5'd5, 1, 1, 0, 5'd0, 0, 0, 0);
    sb.push_back('{RUN, "lu_rt_cleared"});
    @(negedge clk); e = sb.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b want %b", e.nm, obs, e.v); end
    next_cycle(); set_in(5'd9, 5'd2, 1, 0, 1, 5'd9, 0, 0, 0);
    sb.push_back('{LUS, "lu_rs"});
    @(negedge clk); e = sb.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b want %b", e.nm, obs, e.v); end
  endtask

  task automatic test_no_hazard();
    logic [4:0] rs_t[4] = '{5'd0, 5'd6, 5'd5, 5'd5};
    logic [4:0] rt_t[4] = '{5'd0, 5'd7, 5'd5, 5'd5};
    logic       us_t[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic       mr_t[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0] wr_t[4] = '{5'd0, 5'd5, 5'd5, 5'd5};
    for (int i = 0; i < 4; i++) begin
      next_cycle(); set_in(rs_t[i], rt_t[i], us_t[i], us_t[i], mr_t[i], wr_t[i], 0, 0, 0);
      sb.push_back('{RUN, $sformatf("no_lu_%0d", i)});
      @(negedge clk); e = sb.pop_front(); n_chk++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b want %b", e.nm, obs, e.v); end
    end
  endtask

  task automatic test_mult_mfhi();
    next_cycle(); set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0);
    sb.push_back('{RUN, "mult_accept"});
    @(negedge clk); e = sb.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b want %b", e.nm, obs, e.v); end
    for (int i = 0; i < 4; i++) begin
      next_cycle(); set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1);
      sb.push_back('{(i < 3) ? MDS : DONE, $sformatf("mfhi_cyc%0d", i + 1)});
      @(negedge clk); e = sb.pop_front(); n_chk++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b want %b", e.nm, obs, e.v); end
    end
    next_cycle(); idle_in();
    sb.push_back('{RUN, "mult_idle"});
    @(negedge clk); e = sb.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b want %b", e.nm, obs, e.v); end
  endtask

  task automatic test_stalled_start();
    // mult in ID blocked by load-use must not start the unit
    next_cycle(); set_in(5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0);
    sb.push_back('{LUS, "start_blocked"});
    @(negedge clk); e = sb.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b want %b", e.nm, obs, e.v); end
    next_cycle(); set_in(5'd5, 5'd0, 1, 0, 0, 5'd0, 1, 0, 0);
    sb.push_back('{RUN, "start_retry"});
    @(negedge clk); e = sb.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b want %b", e.nm, obs, e.v); end
    for (int i = 0; i < 5; i++) begin
      next_cycle(); idle_in();
      sb.push_back('{(i < 3) ? BSY : ((i == 3) ? DONE : RUN), $sformatf("retry_busy%0d", i + 1)});
      @(negedge clk); e = sb.pop_front(); n_chk++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b want %b", e.nm, obs, e.v); end
    end
  endtask

  task automatic test_back_to_back();
    int busy_cycles = 0;
    next_cycle(); set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0);
    sb.push_back('{RUN, "div1_accept"});
    @(negedge clk); e = sb.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b want %b", e.nm, obs, e.v); end
    // second div waits 15 cycles, then is accepted on the done cycle
    for (int i = 0; i < 16; i++) begin
      next_cycle(); set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0);
      sb.push_back('{(i < 15) ? MDS : DONE, $sformatf("div2_wait%0d", i + 1)});
      @(negedge clk); e = sb.pop_front(); n_chk++;
      if (md_busy === 1'b1) busy_cycles++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b want %b", e.nm, obs, e.v); end
    end
    for (int i = 0; i < 17; i++) begin
      next_cycle(); idle_in();
      sb.push_back('{(i < 15) ? BSY : ((i == 15) ? DONE : RUN), $sformatf("div2_run%0d", i + 1)});
      @(negedge clk); e = sb.pop_front(); n_chk++;
      if (md_busy === 1'b1) busy_cycles++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b want %b", e.nm, obs, e.v); end
    end
    n_chk++;
    if (busy_cycles != 32) begin
      n_fail++; $display("FAIL b2b_busy_len: got %0d want 32", busy_cycles);
    end
  endtask

  task automatic test_reset_mid_busy();
    next_cycle(); set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0);
    sb.push_back('{RUN, "rdiv_accept"});
    @(negedge clk); e = sb.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b want %b", e.nm, obs, e.v); end
    for (int i = 0; i < 4; i++) begin
      next_cycle(); idle_in();
      sb.push_back('{BSY, $sformatf("rdiv_busy%0d", i + 1)});
      @(negedge clk); e = sb.pop_front(); n_chk++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b want %b", e.nm, obs, e.v); end
    end
    next_cycle(); rst = 1'b1;
    sb.push_back('{MDS, "rst_in_busy"});
    @(negedge clk); e = sb.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b want %b", e.nm, obs, e.v); end
    next_cycle();
    sb.push_back('{RSTV, "rst_abandon"});
    @(negedge clk); e = sb.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b want %b", e.nm, obs, e.v); end
    next_cycle(); rst = 1'b0;
    sb.push_back('{RUN, "rst_after_busy"});
    @(negedge clk); e = sb.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %b want %b", e.nm, obs, e.v); end
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    next_cycle(); rst = 1'b1; idle_in();
    next_cycle(); rst = 1'b0;
    @(negedge clk); n_chk++;
    if (lu_stall_cnt !== 32'd0 || md_stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL stats_clear: got %0d/%0d want 0/0", lu_stall_cnt, md_stall_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle(); set_in(5'd3, 5'd4, 1, 1, 1, 5'd4, 0, 0, 0);
      next_cycle(); idle_in();
    end
    next_cycle(); set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      next_cycle(); set_in(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1);
    end
    next_cycle(); idle_in();
    @(negedge clk); n_chk++;
    if (lu_stall_cnt !== 32'd3 || md_stall_cnt !== 32'd3) begin
      n_fail++; $display("FAIL stats_count: got %0d/%0d want 3/3", lu_stall_cnt, md_stall_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mult_mfhi();
    test_stalled_start();
    test_back_to_back();
    test_reset_mid_busy();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Produces the `stall` input of the ID/EX pipeline register, plus the hold enables for PC and IF/ID.
- Detects load-use hazards between the ID and EX stages.
- Tracks the multi-cycle multiply/divide unit in EX with a busy counter. While the unit is busy, it holds any ID-stage instruction that needs HI/LO or the unit.
- Sits between decode and the ID/EX register and is clocked with the pipeline.

Parameters:
- MULT_CYCLES, 4, EX occupancy of a multiply in cycles (≥2).
- DIV_CYCLES, 16, EX occupancy of a divide in cycles (≥2).
- CNT_W, 5, busy counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- RsAddr_id  in  5  Rs of the instruction in ID.
- RtAddr_id  in  5  Rt of the instruction in ID.
- UsesRs_id  in  1  ID instruction reads Rs.
- UsesRt_id  in  1  ID instruction reads Rt.
- MEM_MemRead_ex  in  1  EX instruction is a load.
- WrAddr_ex  in  5  destination register of the EX instruction, after RegDst selection.
- MD_Start_id  in  1  ID instruction is mult/div.
- MD_Op_id  in  1  0 = mult, 1 = div.
- HiLoRead_id  in  1  ID instruction is mfhi/mflo.
- stall  out  1  to ID/EX; bubble inserted on the next edge.
- PC_we  out  1  PC write enable.
- IF_ID_we  out  1  IF/ID write enable.
- md_busy  out  1  multiply/divide unit occupied.
- md_done  out  1  one-cycle pulse in the last busy cycle.

Behaviour:
- Reset: clk single clock; rst synchronous and active-high, sampled only on the rising edge of clk. Reset sets state=IDLE, cnt=0, md_busy=0, md_done=0.
- While rst=1, the outputs are stall=1, PC_we=0, IF_ID_we=0, so a bubble is inserted.
- Load-use hazard:
  - lu = MEM_MemRead_ex & (WrAddr_ex!=0) & ((UsesRs_id & RsAddr_id==WrAddr_ex) | (UsesRt_id & RtAddr_id==WrAddr_ex)).
  - lu is combinational, with zero-cycle latency.
- MD hazard: mh = md_busy & (HiLoRead_id | MD_Start_id) & ~md_done.
  - In the md_done cycle, HI/LO is valid through forwarding, so there is no stall.
- Output equations:
  - stall = lu | mh | rst.
  - PC_we = IF_ID_we = ~stall.
- FSM states:
  - IDLE:
    - If MD_Start_id & ~stall at a rising edge, load cnt = (MD_Op_id ? DIV_CYCLES : MULT_CYCLES) and go to BUSY.
    - Otherwise stay in IDLE.
  - BUSY:
    - md_busy=1.
    - cnt decrements by 1 each edge.
    - md_done=1 when cnt==1.
    - At the edge where cnt==1:
      - If MD_Start_id & ~stall (back-to-back start), reload cnt and stay in BUSY.
      - Otherwise go to IDLE with cnt=0.
- Timing: a mult accepted at edge E gives md_busy high for exactly MULT_CYCLES cycles starting right after E, and md_done in the last of those cycles.
- A stalled MD_Start_id is never accepted; it is re-evaluated every cycle.
- lu and mh can both be true; stall still asserts for a single cycle. No separate priority is needed because they share one output.
- cnt never underflows. In IDLE, cnt=0 and md_done=0.
- Reset mid-BUSY: state goes to IDLE immediately on the next edge and any in-flight operation is abandoned.
- No flush input. A branch flush does not abort an operation already in EX.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined:
  - Adds outputs `lu_stall_cnt [31:0]` and `md_stall_cnt [31:0]`.
  - Counters are synchronously cleared by rst.
  - Each increments on every edge where lu (or mh, respectively) is 1.
  - Both increment when both conditions are true.
  - Counters saturate at 0xFFFFFFFF.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Load-use on Rt: EX `lw $5`, ID `add $6,$5,$7` (UsesRt, Rt=5) → stall=1, PC_we=0 for 1 cycle; stall=0 once the load leaves EX.
- Load to $0 with an ID reader of $0 → stall=0. A load to $5 with an ID instruction that does not use $5 → stall=0.
- mult accepted at edge E, ID=mfhi from E+1 → md_busy high for 4 cycles; stall high for the first 3 of them; md_done pulses in the 4th with stall=0.
- div accepted, then a second div in ID → stalled for 15 cycles and accepted at the 16th edge; md_busy stays continuously high for 32 cycles.
- rst asserted in the 5th cycle of a div → next edge: md_busy=0, state IDLE; stall=1 while rst=1, then stall=0 with idle inputs.
- With HAZARD_STATS_EN: 3 load-use stalls plus one full mult/mfhi sequence → lu_stall_cnt=3, md_stall_cnt=3.
